// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM encoding
// and the latched operation/response payloads.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CONF_W = 5;

    typedef enum logic [CONF_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_XOR  = 5'd4,
        OP_NOR  = 5'd5,
        OP_SL   = 5'd6,
        OP_SR   = 5'd7,
        OP_COMP = 5'd8
    } op_code_t;

    localparam logic [CONF_W-1:0] OP_MAX = 5'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [CONF_W-1:0] conf;
        logic              sign;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              err;
    } alu_rsp_t;

    // Codes above OP_MAX are accepted but never issued to the ALU.
    function automatic logic op_legal(input logic [CONF_W-1:0] conf);
        return conf <= OP_MAX;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot grant, the requester not granted last
// wins a tie, a lone requester always wins.
module rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant_c
);

    always_comb begin
        grant_c = {valid1, valid0};
        if (valid0 && valid1) begin
            grant_c = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared external ALU: accept in IDLE,
// issue for one EXEC cycle, hold the response in RESP until the owner takes it.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_conf,
    input  logic        req0_sign,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_conf,
    input  logic        req1_sign,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err,

    output logic [4:0]  alu_conf,
    output logic        alu_sign,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,

    output logic        busy
);

    state_t     state_q, state_d;
    alu_op_t    alu_q, alu_d;
    alu_rsp_t   rsp_q, rsp_d;
    logic       illegal_q, illegal_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] rsp_valid_q, rsp_valid_d;
    logic       busy_q, busy_d;

    logic [1:0] grant_c;
    logic [1:0] accept_c;
    logic       idle_c;
    alu_op_t    req_op_c;

    rr_pick2 u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant_c    (grant_c)
    );

    // Ready is combinational on valid; suppressed outside IDLE and while in reset.
    assign idle_c     = (state_q == ST_IDLE) && !reset;
    assign req0_ready = idle_c && grant_c[0];
    assign req1_ready = idle_c && grant_c[1];
    assign accept_c   = {req1_valid && req1_ready, req0_valid && req0_ready};

    always_comb begin
        req_op_c = '0;
        if (accept_c[1]) begin
            req_op_c.conf = req1_conf;
            req_op_c.sign = req1_sign;
            req_op_c.a    = req1_a;
            req_op_c.b    = req1_b;
        end else begin
            req_op_c.conf = req0_conf;
            req_op_c.sign = req0_sign;
            req_op_c.a    = req0_a;
            req_op_c.b    = req0_b;
        end
    end

    // Next-state and register updates; the ALU bundle is only non-zero in EXEC.
    always_comb begin
        state_d      = state_q;
        alu_d        = '0;
        rsp_d        = rsp_q;
        illegal_d    = illegal_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (|accept_c) begin
                    owner_d      = accept_c[1];
                    last_grant_d = accept_c[1];
                    illegal_d    = !op_legal(req_op_c.conf);
                    alu_d        = op_legal(req_op_c.conf) ? req_op_c : '0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (illegal_q) begin
                    rsp_d.result = '0;
                    rsp_d.zero   = 1'b0;
                    rsp_d.err    = 1'b1;
                end else begin
                    rsp_d.result = alu_result;
                    rsp_d.zero   = alu_zero;
                    rsp_d.err    = 1'b0;
                end
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (owner_q ? rsp1_ready : rsp0_ready) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            alu_q        <= '0;
            rsp_q        <= '0;
            illegal_q    <= 1'b0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_q        <= alu_d;
            rsp_q        <= rsp_d;
            illegal_q    <= illegal_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_conf    = alu_q.conf;
    assign alu_sign    = alu_q.sign;
    assign alu_in1     = alu_q.a;
    assign alu_in2     = alu_q.b;

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp0_result = rsp_q.result;
    assign rsp0_zero   = rsp_q.zero;
    assign rsp0_err    = rsp_q.err;

    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp1_result = rsp_q.result;
    assign rsp1_zero   = rsp_q.zero;
    assign rsp1_err    = rsp_q.err;

    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU beside the DUT.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_ready, req0_sign;
    logic [4:0]  req0_conf;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sign;
    logic [4:0]  req1_conf;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp1_result;
    logic [4:0]  alu_conf;
    logic        alu_sign;
    logic [31:0] alu_in1, alu_in2, alu_result;
    logic        alu_zero;
    logic        busy;

    typedef struct {
        logic        id;
        logic [4:0]  conf;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   n_vec = 0;
    int   n_err = 0;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_conf(req0_conf),
        .req0_sign(req0_sign), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_conf(req1_conf),
        .req1_sign(req1_sign), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_conf(alu_conf), .alu_sign(alu_sign), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU living beside the arbiter
    always_comb begin
        alu_result = 32'd0;
        case (alu_conf)
            5'd0: alu_result = alu_in1 + alu_in2;
            5'd1: alu_result = alu_in1 - alu_in2;
            5'd2: alu_result = alu_in1 & alu_in2;
            5'd3: alu_result = alu_in1 | alu_in2;
            5'd4: alu_result = alu_in1 ^ alu_in2;
            5'd5: alu_result = ~(alu_in1 | alu_in2);
            5'd6: alu_result = alu_in1 << alu_in2[4:0];
            5'd7: begin
                if (alu_sign) alu_result = $signed(alu_in1) >>> alu_in2[4:0];
                else          alu_result = alu_in1 >> alu_in2[4:0];
            end
            5'd8: begin
                if (alu_sign) alu_result = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
                else          alu_result = {31'd0, alu_in1 < alu_in2};
            end
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input vec_t v, input logic valid);
        if (v.id) begin
            req1_valid = valid; req1_conf = v.conf; req1_sign = v.sign;
            req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = valid; req0_conf = v.conf; req0_sign = v.sign;
            req0_a = v.a; req0_b = v.b;
        end
    endtask

    // Wait (bounded) for acceptance, push expectation, return at the EXEC negedge.
    task automatic accept(input vec_t v);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (v.id ? req1_ready : req0_ready) begin
                got = 1'b1;
                sb.push_back('{id: v.id, res: v.res, zero: v.zero, err: v.err});
            end else begin
                @(negedge clk);
            end
        end
        chk1("accept", got, 1'b1);
        @(negedge clk);
        if (v.id) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    task automatic check_pop(input logic id);
        exp_t e;
        if (sb.size() == 0) begin
            chk1("scoreboard_nonempty", 1'b0, 1'b1);
        end else begin
            e = sb.pop_front();
            chk1("rsp_owner", id, e.id);
            chk32("rsp_result", id ? rsp1_result : rsp0_result, e.res);
            chk1("rsp_zero", id ? rsp1_zero : rsp0_zero, e.zero);
            chk1("rsp_err", id ? rsp1_err : rsp0_err, e.err);
        end
    endtask

    // From the EXEC negedge: check issue, response two cycles after acceptance, return to IDLE.
    task automatic complete(input vec_t v);
        chk32("exec_conf", 32'(alu_conf), v.err ? 32'd0 : 32'(v.conf));
        if (!v.err) begin
            chk32("exec_in1", alu_in1, v.a);
            chk32("exec_in2", alu_in2, v.b);
            chk1("exec_sign", alu_sign, v.sign);
        end
        chk1("exec_busy", busy, 1'b1);
        chk1("exec_rsp_valid", v.id ? rsp1_valid : rsp0_valid, 1'b0);
        @(negedge clk);
        chk1("rsp_valid", v.id ? rsp1_valid : rsp0_valid, 1'b1);
        chk1("rsp_other_valid", v.id ? rsp0_valid : rsp1_valid, 1'b0);
        chk32("resp_alu_conf", 32'(alu_conf), 32'd0);
        check_pop(v.id);
        @(negedge clk);
        chk1("post_rsp_valid", v.id ? rsp1_valid : rsp0_valid, 1'b0);
        chk1("post_busy", busy, 1'b0);
    endtask

    task automatic issue(input vec_t v);
        drive_req(v, 1'b1);
        accept(v);
        complete(v);
    endtask

    task automatic tie(input logic exp_win, input logic [31:0] k);
        vec_t v0, v1;
        v0 = '{1'b0, 5'd0, 1'b0, 32'd100 + k, 32'd1, 32'd101 + k, 1'b0, 1'b0};
        v1 = '{1'b1, 5'd1, 1'b0, 32'd50, 32'd8, 32'd42, 1'b0, 1'b0};
        drive_req(v0, 1'b1);
        drive_req(v1, 1'b1);
        #1;
        chk1("tie_ready0", req0_ready, exp_win == 1'b0);
        chk1("tie_ready1", req1_ready, exp_win == 1'b1);
        accept(exp_win ? v1 : v0);
        #1;
        chk1("exec_loser_ready", exp_win ? req0_ready : req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        complete(exp_win ? v1 : v0);
    endtask

    initial begin
        vec_t v, w;

        vecs[0]  = '{1'b0, 5'd0,  1'b0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd1,  1'b0, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd2,  1'b0, 32'h0000_f0f0,  32'h0000_0ff0,  32'h0000_00f0,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd3,  1'b0, 32'hf000_0000,  32'h0000_0001,  32'hf000_0001,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd4,  1'b0, 32'hffff_ffff,  32'h0f0f_0f0f,  32'hf0f0_f0f0,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd5,  1'b0, 32'd0,          32'd0,          32'hffff_ffff,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd6,  1'b0, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'd7,  1'b1, 32'h8000_0000,  32'd4,          32'hf800_0000,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd7,  1'b0, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd8,  1'b1, 32'hffff_ffff,  32'd1,          32'd1,          1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd8,  1'b0, 32'hffff_ffff,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[11] = '{1'b0, 5'd12, 1'b0, 32'd3,          32'd4,          32'd0,          1'b0, 1'b1};
        vecs[12] = '{1'b1, 5'd31, 1'b1, 32'd1,          32'd1,          32'd0,          1'b0, 1'b1};

        reset = 1'b1;
        req0_valid = 1'b1; req0_conf = 5'd0; req0_sign = 1'b0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_conf = 5'd0; req1_sign = 1'b0; req1_a = 32'd2; req1_b = 32'd2;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state with both requests pending
        chk1("rst_req0_ready", req0_ready, 1'b0);
        chk1("rst_req1_ready", req1_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
        chk1("rst_rsp0_err", rsp0_err, 1'b0);
        chk32("rst_alu_conf", 32'(alu_conf), 32'd0);
        chk32("rst_alu_in1", alu_in1, 32'd0);
        chk32("rst_alu_in2", alu_in2, 32'd0);
        chk1("rst_alu_sign", alu_sign, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Ties alternate, requester 0 first after reset
        tie(1'b0, 32'd0);
        tie(1'b1, 32'd0);
        tie(1'b0, 32'd7);

        foreach (vecs[i]) issue(vecs[i]);

        // Back-pressure: owner holds rsp0_ready low, req1 must wait
        v = '{1'b0, 5'd0, 1'b0, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0};
        w = '{1'b1, 5'd4, 1'b0, 32'h0000_00ff, 32'h0000_000f, 32'h0000_00f0, 1'b0, 1'b0};
        rsp0_ready = 1'b0;
        drive_req(v, 1'b1);
        accept(v);
        drive_req(w, 1'b1);
        #1;
        chk1("bp_exec_req1_ready", req1_ready, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
            chk32("bp_rsp0_result", rsp0_result, 32'd42);
            chk1("bp_req1_ready", req1_ready, 1'b0);
            chk1("bp_busy", busy, 1'b1);
            chk1("bp_rsp1_valid", rsp1_valid, 1'b0);
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        check_pop(1'b0);
        @(negedge clk);
        chk1("bp_rsp0_released", rsp0_valid, 1'b0);
        accept(w);
        complete(w);

        // Reset during EXEC aborts the operation
        v = '{1'b0, 5'd3, 1'b0, 32'h0000_0f00, 32'h0000_00f0, 32'h0000_0ff0, 1'b0, 1'b0};
        drive_req(v, 1'b1);
        accept(v);
        chk32("abort_exec_conf", 32'(alu_conf), 32'd3);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_rsp0_valid", rsp0_valid, 1'b0);
        chk1("abort_rsp0_err", rsp0_err, 1'b0);
        chk32("abort_alu_conf", 32'(alu_conf), 32'd0);
        chk32("abort_alu_in1", alu_in1, 32'd0);
        chk1("abort_req0_ready", req0_ready, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("abort_no_rsp0", rsp0_valid, 1'b0);
            chk1("abort_idle", busy, 1'b0);
        end
        tie(1'b0, 32'd20);

        chk32("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
